// File: rtl/siwo_fetch.sv
// siwo_fetch: instruction fetch stage of the SIWO 16-bit core.
// Issues sequential word addresses to instruction memory and buffers the
// returned instructions with their addresses in a DEPTH-entry FIFO. The FIFO
// drains downstream over a valid/ready handshake. A redirect flushes the FIFO
// and restarts fetch. Fetch stops once HLT (16'h0) has been delivered.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   mem_req_valid/addr/ready     fetch request to instruction memory
//   mem_rsp_valid/data           in-order instruction return
//   out_valid/insn/pc/ready      instruction handshake to decode
//   redirect_valid/addr          taken branch/jump: flush and restart
//   halted                       HLT has been consumed downstream
//
// Build option: define SIWO_FETCH_NOP_SQUASH_EN to drop NOP (16'h1) responses
// instead of enqueuing them.
module siwo_fetch #(
    parameter int unsigned INSN_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] mem_rsp_data,
    output logic                  out_valid,
    output logic [INSN_WIDTH-1:0] out_insn,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [INSN_WIDTH-1:0] HLT_INSN = '0;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  run_q, run_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [INSN_WIDTH-1:0] insn_q [DEPTH];
    logic [INSN_WIDTH-1:0] insn_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];

    logic req_fire;
    logic pop;
    logic rsp_live;
    logic rsp_nop;
    logic push;

    // Squashed NOPs still consume an address slot.
`ifdef SIWO_FETCH_NOP_SQUASH_EN
    localparam logic [INSN_WIDTH-1:0] NOP_INSN = INSN_WIDTH'(1);
    assign rsp_nop = (mem_rsp_data == NOP_INSN);
`else
    assign rsp_nop = 1'b0;
`endif

    // run_q holds off the first request until the cycle after reset releases.
    assign mem_req_valid = run_q && (state_q == FETCH) && !redirect_valid &&
                           ((SUM_W'(count_q) + SUM_W'(outst_q)) < SUM_W'(DEPTH));
    assign mem_req_addr  = pc_q;
    assign out_valid     = (count_q != '0);
    assign out_insn      = insn_q[head_q];
    assign out_pc        = addr_q[head_q];
    assign halted        = (state_q == HALTED);

    assign req_fire = mem_req_valid && mem_req_ready;
    assign pop      = out_valid && out_ready;
    // A response belongs to the current stream once all stale ones are dropped.
    assign rsp_live = mem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign push     = rsp_live && (state_q == FETCH) && !rsp_nop;

    // Next-state logic for counters, FIFO and fetch state.
    always_comb begin
        state_d  = state_q;
        run_d    = 1'b1;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q;
        count_d  = count_q;
        drop_d   = drop_q;
        head_d   = head_q;
        tail_d   = tail_q;
        insn_d   = insn_q;
        addr_d   = addr_q;

        if (req_fire) begin
            outst_d = outst_d + CNT_W'(1);
        end
        if (mem_rsp_valid) begin
            outst_d = outst_d - CNT_W'(1);
        end

        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale.
            state_d  = FETCH;
            pc_d     = redirect_addr;
            rsp_pc_d = redirect_addr;
            count_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            drop_d   = outst_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + ADDR_WIDTH'(1);
            end
            if (mem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(1);
            end
            if (push) begin
                insn_d[tail_q] = mem_rsp_data;
                addr_d[tail_q] = rsp_pc_q;
                tail_d         = tail_q + PTR_W'(1);
                if (mem_rsp_data == HLT_INSN) begin
                    state_d = HALT_PEND;
                end
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
                // Only the HLT entry can hold 16'h0 while halt is pending.
                if ((state_q == HALT_PEND) && (out_insn == HLT_INSN)) begin
                    state_d = HALTED;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            run_q    <= 1'b0;
            pc_q     <= '0;
            rsp_pc_q <= '0;
            outst_q  <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            insn_q   <= '{default: '0};
            addr_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            insn_q   <= insn_d;
            addr_q   <= addr_d;
        end
    end

endmodule

// File: doc/siwo_fetch.md
# siwo_fetch

Instruction fetch stage of the SIWO 16-bit core, directly upstream of the decode/execute stage. It generates sequential word addresses starting at address 0, issues them to instruction memory over a request/response interface, and buffers returned instructions with their addresses in a small FIFO. It delivers instructions downstream with a valid/ready handshake, supports branch/jump redirect with flush of in-flight fetches, and stops fetching on the HLT instruction (16'h0).

## Interface
- INSN_WIDTH, 16, instruction width
- ADDR_WIDTH, 16, instruction address width (word-addressed)
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  ADDR_WIDTH  fetch address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  instruction word returned; responses arrive in request order, ≥1 cycle after acceptance
- mem_rsp_data  in  INSN_WIDTH  returned instruction
- out_valid  out  1  instruction available to downstream
- out_insn  out  INSN_WIDTH  instruction
- out_pc  out  ADDR_WIDTH  address of out_insn
- out_ready  in  1  downstream accepts instruction
- redirect_valid  in  1  branch/jump taken; flush and restart
- redirect_addr  in  ADDR_WIDTH  new fetch address
- halted  out  1  HLT consumed; fetch stopped

## Operation
- States: FETCH, HALT_PEND, HALTED. Reset → FETCH.
- Counters: pc (next request address), outstanding (accepted requests without response, 0..DEPTH), count (FIFO occupancy, 0..DEPTH), drop (responses to discard, 0..DEPTH).
- Request: mem_req_valid = (state==FETCH) && !redirect_valid && (count+outstanding < DEPTH); mem_req_addr = pc. On accept (valid&&ready): pc ← pc+1 (wraps FFFF→0000), outstanding+1.
- Response: outstanding−1. If drop>0: discarded, drop−1. Else if state==HALT_PEND: discarded. Else enqueued with its address (tracked by an in-order address counter, or stored per outstanding request).
- HLT: an enqueued response equal to 16'h0 sets state ← HALT_PEND; later responses are discarded. When the HLT entry is popped (out_valid&&out_ready), state ← HALTED, halted=1. HLT is delivered downstream like any instruction.
- Pop: out_valid = count>0; head entry presented; pop on out_valid&&out_ready.
- Redirect (highest priority, any state): FIFO cleared (count←0), pc ← redirect_addr, state ← FETCH, halted ← 0, drop ← outstanding after this cycle's response is accounted for (a response arriving in the redirect cycle is itself discarded). No request is issued in the redirect cycle. A pop handshake in the same cycle is treated as completed.
- The credit rule guarantees no overflow; simultaneous push and pop when full is legal.

## Timing
- Reset values: mem_req_valid=0, mem_req_addr=0, out_valid=0, out_insn=0, out_pc=0, halted=0; pc=0, all counters 0.
- First request is asserted in the cycle after reset deasserts, with addr 0.
- Response at cycle N → out_valid at N+1 if the FIFO was empty (registered storage, no bypass).
- Throughput: 1 instruction/cycle sustained when memory returns 1 response/cycle and out_ready=1.
- Redirect at cycle N → first request for redirect_addr at N+1.
- A reset asserted mid-operation overrides everything; outstanding memory responses after reset are the memory's responsibility (memory is also reset).

## Configuration
- SIWO_FETCH_NOP_SQUASH_EN defined: responses equal to NOP (16'h1) are not enqueued (treated as consumed); the address counter still advances past them; out_pc of the next instruction skips the NOP address.
- Undefined: NOPs are enqueued and delivered like any other instruction.

## Test plan
- Reset, memory 1-cycle latency, out_ready=1, memory holds 0x8001,0x8002,… → out_pc 0,1,2,… with matching out_insn, one per cycle after initial 2-cycle fill.
- out_ready=0 with DEPTH=4 → exactly 4 requests accepted, mem_req_valid then 0; release out_ready → addresses continue at 4 with no loss or duplication.
- Redirect to 0x0100 while 3 requests outstanding → those 3 responses dropped; next out_pc=0x0100.
- HLT (0x0000) returned at address 5 → instructions 0–5 delivered, later responses dropped, halted=1 after pop of 5; redirect to 0x0020 → halted=0, fetch resumes at 0x0020.
- pc wrap: redirect to 0xFFFE → out_pc 0xFFFE, 0xFFFF, 0x0000.
- With SIWO_FETCH_NOP_SQUASH_EN, memory 0x8000,0x0001,0x8002 at 0–2 → outputs (0,0x8000),(2,0x8002); without it, three outputs.
